// File: rtl/inst_encode_loader_if.sv
// Request and instruction-memory write bundle for inst_encode_loader.
// The slave view belongs to the encoder; the master view drives requests and acts as memory.
interface inst_encode_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport slave (
    input  in_valid, in_fmt, in_rd, in_rs1, in_rs2,
    input  in_funct3, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_fmt, in_rd, in_rs1, in_rs2,
    output in_funct3, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_encode_loader.sv
// Packs format/fields/immediate into RV32 words and streams them to imem.
// Optional IMM_RANGE_CHECK_EN rejects immediates that would not decode back.
module inst_encode_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  inst_encode_loader_if.slave bus,
  output logic [ADDR_W-1:0] word_cnt,
  output logic              err
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cnt;
  logic [31:0]       wdata;
  logic [31:0]       enc;
  logic              fmt_ok;
  logic              bad;
  logic              acc;

  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;

  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign f3  = bus.in_funct3;

  always_comb begin
    enc    = '0;
    fmt_ok = 1'b1;
    case (bus.in_fmt)
      3'd0: enc = {imm[11:0], rs1, f3, rd, 7'b0000011};
      3'd1: enc = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'd2: enc = {imm[12], imm[10:5], rs2, rs1, f3,
                   imm[4:1], imm[11], 7'b1100011};
      3'd3: enc = {imm[11:0], rs1, f3, rd, 7'b0010011};
      3'd4: enc = {imm[31:12], rd, 7'b0110111};
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic rng_ok;

  always_comb begin
    rng_ok = 1'b1;
    case (bus.in_fmt)
      3'd0, 3'd1, 3'd3:
        rng_ok = (&imm[31:11]) | ~(|imm[31:11]);
      3'd2:
        rng_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      3'd4:
        rng_ok = ~(|imm[11:0]);
      default: rng_ok = 1'b1;
    endcase
  end

  assign bad = ~fmt_ok | ~rng_ok;
`else
  assign bad = ~fmt_ok;
`endif

  assign bus.in_ready  = reset_n & (state == IDLE);
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign word_cnt      = cnt;
  assign acc           = bus.in_valid & bus.in_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (acc && !bad) state_n = WRITE;
      WRITE: if (bus.mem_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      wdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      err   <= acc & bad;
      if (state == IDLE) begin
        // a same-cycle accept lands at the freshly loaded base
        if (base_load) begin
          addr <= {base_addr[ADDR_W-1:2], 2'b00};
          cnt  <= '0;
        end
        if (acc && !bad) wdata <= enc;
      end else if (bus.mem_ready) begin
        addr <= addr + ADDR_W'(4);
        cnt  <= cnt + ADDR_W'(1);
      end
    end
  end

endmodule
